// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes non-memory ops through and runs a
// req/ack data-bus transaction for loads and stores, with big-endian lane handling.
module mem_access #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        ex_wd,
   input  logic              ex_wreg,
   input  logic [31:0]       ex_wdata,
   input  logic [3:0]        ex_mem_op,
   input  logic [ADDR_W-1:0] ex_mem_addr,
   input  logic [31:0]       ex_mem_sdata,
   output logic [4:0]        mem_wd,
   output logic              mem_wreg,
   output logic [31:0]       mem_wdata,
   output logic              stallreq,
   output logic              excp_adel,
   output logic              excp_ades,
   output logic              dbus_req,
   output logic              dbus_we,
   output logic [ADDR_W-1:0] dbus_addr,
   output logic [3:0]        dbus_sel,
   output logic [31:0]       dbus_wdata,
   input  logic              dbus_ack,
   input  logic [31:0]       dbus_rdata
);

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        sel_q, sel_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       result_q, result_d;

   logic        is_load, is_store, is_byte, is_half, misaligned;
   logic [1:0]  lane;
   logic [3:0]  sel_calc;
   logic [31:0] sdata_calc, load_val;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign lane     = ex_mem_addr[1:0];
   assign is_load  = (ex_mem_op >= OP_LB) && (ex_mem_op <= OP_LW);
   assign is_store = (ex_mem_op >= OP_SB) && (ex_mem_op <= OP_SW);
   assign is_byte  = (ex_mem_op == OP_LB) || (ex_mem_op == OP_LBU) || (ex_mem_op == OP_SB);
   assign is_half  = (ex_mem_op == OP_LH) || (ex_mem_op == OP_LHU) || (ex_mem_op == OP_SH);
   assign misaligned = (is_half && lane[0]) ||
                       ((ex_mem_op == OP_LW || ex_mem_op == OP_SW) && (lane != 2'b00));

   // Lane select and store replication; byte 0 of the word lives in bits 31:24.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      sel_calc   = 4'b1111;
      sdata_calc = ex_mem_sdata;
      if (is_byte) begin
         sel_calc   = 4'b1000 >> lane;
         sdata_calc = {4{ex_mem_sdata[7:0]}};
      end else if (is_half) begin
         sel_calc   = lane[1] ? 4'b0011 : 4'b1100;
         sdata_calc = {2{ex_mem_sdata[15:0]}};
      end
   end

   always_comb begin
      ld_byte  = dbus_rdata[31:24];
      case (lane)
         2'b00:   ld_byte = dbus_rdata[31:24];
         2'b01:   ld_byte = dbus_rdata[23:16];
         2'b10:   ld_byte = dbus_rdata[15:8];
         default: ld_byte = dbus_rdata[7:0];
      endcase
      ld_half  = lane[1] ? dbus_rdata[15:0] : dbus_rdata[31:16];
      case (ex_mem_op)
         OP_LB:   load_val = {{24{ld_byte[7]}}, ld_byte};
         OP_LBU:  load_val = {24'd0, ld_byte};
         OP_LH:   load_val = {{16{ld_half[15]}}, ld_half};
         OP_LHU:  load_val = {16'd0, ld_half};
         default: load_val = dbus_rdata;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      sel_d     = sel_q;
      wdata_d   = wdata_q;
      result_d  = result_q;
      mem_wd    = ex_wd;
      mem_wreg  = ex_wreg;
      mem_wdata = ex_wdata;
      stallreq  = 1'b0;
      excp_adel = 1'b0;
      excp_ades = 1'b0;

      case (state_q)
         IDLE: begin
            if (is_load || is_store) begin
               mem_wreg = 1'b0;
               if (misaligned) begin
                  excp_adel = is_load;
                  excp_ades = is_store;
               end else begin
                  stallreq = 1'b1;
                  req_d    = 1'b1;
                  we_d     = is_store;
                  addr_d   = {ex_mem_addr[ADDR_W-1:2], 2'b00};
                  sel_d    = sel_calc;
                  wdata_d  = sdata_calc;
                  state_d  = BUSY;
               end
            end
         end
         BUSY: begin
            stallreq = 1'b1;
            mem_wreg = 1'b0;
            if (dbus_ack) begin
               result_d = load_val;
               req_d    = 1'b0;
               we_d     = 1'b0;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (is_load) mem_wdata = result_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (rst) begin
         mem_wd    = 5'd0;
         mem_wreg  = 1'b0;
         mem_wdata = 32'd0;
         stallreq  = 1'b0;
         excp_adel = 1'b0;
         excp_ades = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         sel_q    <= 4'd0;
         wdata_q  <= 32'd0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         sel_q    <= sel_d;
         wdata_q  <= wdata_d;
         result_q <= result_d;
      end
   end

   assign dbus_req   = req_q;
   assign dbus_we    = we_q;
   assign dbus_addr  = addr_q;
   assign dbus_sel   = sel_q;
   assign dbus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed-vector bench for mem_access: pass-through, loads/stores with ack
// delays, misalignment exceptions, back-to-back ops and reset mid-transaction.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  ex_wd;
   logic        ex_wreg;
   logic [31:0] ex_wdata;
   logic [3:0]  ex_mem_op;
   logic [31:0] ex_mem_addr;
   logic [31:0] ex_mem_sdata;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic        stallreq, excp_adel, excp_ades;
   logic        dbus_req, dbus_we;
   logic [31:0] dbus_addr;
   logic [3:0]  dbus_sel;
   logic [31:0] dbus_wdata;
   logic        dbus_ack;
   logic [31:0] dbus_rdata;

   int n_cmp = 0;
   int n_err = 0;

   mem_access #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
      .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_mem_sdata(ex_mem_sdata),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .stallreq(stallreq), .excp_adel(excp_adel), .excp_ades(excp_ades),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
      .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
      .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_nop(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
      ex_mem_op    = 4'd0;
      ex_wd        = wd;
      ex_wreg      = wreg;
      ex_wdata     = wdata;
      ex_mem_addr  = 32'd0;
      ex_mem_sdata = 32'd0;
   endtask

   // Issues one aligned memory op starting in IDLE; ack arrives after 'delay'
   // extra BUSY cycles. Returns in IDLE after the DONE edge.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] rdata, input int delay,
                         input logic [3:0] exp_sel, input logic [31:0] exp_bwdata,
                         input logic [31:0] exp_res);
      logic is_st;
      int   stall_cnt;
      int   req_cnt;
      is_st        = (op >= 4'd6);
      ex_mem_op    = op;
      ex_mem_addr  = addr;
      ex_mem_sdata = sdata;
      ex_wd        = 5'd9;
      ex_wreg      = !is_st;
      ex_wdata     = 32'h5555_0000;
      stall_cnt    = 0;
      req_cnt      = 0;
      #1;
      check({tag, " idle stallreq"}, 32'(stallreq), 32'd1);
      check({tag, " idle mem_wreg"}, 32'(mem_wreg), 32'd0);
      check({tag, " idle req"}, 32'(dbus_req), 32'd0);
      if (stallreq) stall_cnt++;
      tick();
      check({tag, " we"}, 32'(dbus_we), 32'(is_st));
      check({tag, " addr"}, dbus_addr, {addr[31:2], 2'b00});
      check({tag, " sel"}, 32'(dbus_sel), 32'(exp_sel));
      if (is_st) check({tag, " bus wdata"}, dbus_wdata, exp_bwdata);
      for (int i = 0; i < delay; i++) begin
         check({tag, " busy mem_wreg"}, 32'(mem_wreg), 32'd0);
         if (stallreq) stall_cnt++;
         if (dbus_req) req_cnt++;
         tick();
         check({tag, " held sel"}, 32'(dbus_sel), 32'(exp_sel));
      end
      dbus_ack   = 1'b1;
      dbus_rdata = rdata;
      #1;
      if (stallreq) stall_cnt++;
      if (dbus_req) req_cnt++;
      tick();
      dbus_ack   = 1'b0;
      dbus_rdata = 32'hBAD0_BAD0;
      #1;
      check({tag, " stall cycles"}, 32'(stall_cnt), 32'(2 + delay));
      check({tag, " req cycles"}, 32'(req_cnt), 32'(1 + delay));
      check({tag, " done stallreq"}, 32'(stallreq), 32'd0);
      check({tag, " done req"}, 32'(dbus_req), 32'd0);
      check({tag, " done we"}, 32'(dbus_we), 32'd0);
      check({tag, " done mem_wd"}, 32'(mem_wd), 32'd9);
      check({tag, " done mem_wreg"}, 32'(mem_wreg), 32'(!is_st));
      check({tag, " done mem_wdata"}, mem_wdata, exp_res);
      tick();
      set_nop(5'd0, 1'b0, 32'd0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst        = 1'b1;
      dbus_ack   = 1'b0;
      dbus_rdata = 32'd0;
      set_nop(5'd5, 1'b1, 32'h1234);
      tick();
      tick();
      check("rst mem_wreg forced", 32'(mem_wreg), 32'd0);
      check("rst mem_wd forced", 32'(mem_wd), 32'd0);
      check("rst mem_wdata forced", mem_wdata, 32'd0);
      check("rst dbus_req", 32'(dbus_req), 32'd0);
      check("rst dbus_sel", 32'(dbus_sel), 32'd0);
      rst = 1'b0;
      #1;

      check("nop mem_wd", 32'(mem_wd), 32'd5);
      check("nop mem_wreg", 32'(mem_wreg), 32'd1);
      check("nop mem_wdata", mem_wdata, 32'h1234);
      check("nop stallreq", 32'(stallreq), 32'd0);
      tick();
      check("nop dbus_req", 32'(dbus_req), 32'd0);

      // Invalid op behaves as NOP; an ack while idle is ignored.
      ex_mem_op = 4'd12;
      dbus_ack  = 1'b1;
      #1;
      check("op12 mem_wdata", mem_wdata, 32'h1234);
      check("op12 stallreq", 32'(stallreq), 32'd0);
      tick();
      dbus_ack = 1'b0;
      check("op12 dbus_req", 32'(dbus_req), 32'd0);
      set_nop(5'd0, 1'b0, 32'd0);
      tick();

      run_op("LB",  4'd1, 32'h1001, 32'd0, 32'h11F0_2233, 0, 4'b0100, 32'd0, 32'hFFFF_FFF0);
      run_op("LBU", 4'd2, 32'h1001, 32'd0, 32'h11F0_2233, 0, 4'b0100, 32'd0, 32'h0000_00F0);
      run_op("SH",  4'd7, 32'h2002, 32'hAAAA_8765, 32'd0, 3, 4'b0011, 32'h8765_8765, 32'h5555_0000);
      run_op("SB",  4'd6, 32'h2003, 32'h0000_00C3, 32'd0, 1, 4'b0001, 32'hC3C3_C3C3, 32'h5555_0000);
      run_op("LHU", 4'd4, 32'h2000, 32'd0, 32'h9ABC_0001, 0, 4'b1100, 32'd0, 32'h0000_9ABC);
      run_op("LW",  4'd5, 32'h4000, 32'd0, 32'hDEAD_BEEF, 0, 4'b1111, 32'd0, 32'hDEAD_BEEF);
      run_op("LH",  4'd3, 32'h4006, 32'd0, 32'h0000_807F, 0, 4'b0011, 32'd0, 32'hFFFF_807F);

      // Misaligned word load.
      ex_mem_op   = 4'd5;
      ex_mem_addr = 32'h3002;
      ex_wreg     = 1'b1;
      #1;
      check("adel pulse", 32'(excp_adel), 32'd1);
      check("adel ades", 32'(excp_ades), 32'd0);
      check("adel mem_wreg", 32'(mem_wreg), 32'd0);
      check("adel stallreq", 32'(stallreq), 32'd0);
      tick();
      set_nop(5'd0, 1'b0, 32'd0);
      #1;
      check("adel no req", 32'(dbus_req), 32'd0);
      check("adel cleared", 32'(excp_adel), 32'd0);

      // Misaligned word store.
      ex_mem_op   = 4'd8;
      ex_mem_addr = 32'h3001;
      #1;
      check("ades pulse", 32'(excp_ades), 32'd1);
      check("ades adel", 32'(excp_adel), 32'd0);
      check("ades stallreq", 32'(stallreq), 32'd0);
      tick();
      set_nop(5'd0, 1'b0, 32'd0);
      #1;
      check("ades no req", 32'(dbus_req), 32'd0);
      check("ades cleared", 32'(excp_ades), 32'd0);

      // Reset while BUSY abandons the transaction.
      ex_mem_op   = 4'd5;
      ex_mem_addr = 32'h5000;
      tick();
      check("midrst busy req", 32'(dbus_req), 32'd1);
      rst = 1'b1;
      #1;
      check("midrst stall forced", 32'(stallreq), 32'd0);
      tick();
      rst = 1'b0;
      set_nop(5'd3, 1'b1, 32'h0000_7777);
      #1;
      check("midrst req cleared", 32'(dbus_req), 32'd0);
      check("midrst idle passthru", mem_wdata, 32'h0000_7777);
      dbus_ack   = 1'b1;
      dbus_rdata = 32'hFFFF_FFFF;
      tick();
      dbus_ack = 1'b0;
      tick();
      check("late ack req", 32'(dbus_req), 32'd0);
      check("late ack stall", 32'(stallreq), 32'd0);
      check("late ack mem_wdata", mem_wdata, 32'h0000_7777);
      check("late ack mem_wreg", 32'(mem_wreg), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access pipeline stage that sits between the EX/MEM pipeline register and the MEM/WB register; it feeds mem_wd/mem_wreg/mem_wdata into MEM/WB.
- Non-memory instructions pass straight through combinationally.
- Loads and stores run a multi-cycle request/acknowledge transaction on the data bus; stallreq freezes the upstream pipeline meanwhile.
- Handles big-endian byte/halfword/word alignment, load sign/zero extension, and misaligned-address detection.

Parameters:
- ADDR_W, 32, data-bus address width; ex_mem_addr[ADDR_W-1:0].

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ex_wd  in  5  destination register address from EX/MEM.
- ex_wreg  in  1  destination write enable from EX/MEM.
- ex_wdata  in  32  ALU result from EX/MEM.
- ex_mem_op  in  4  0 NOP, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9–15 behave as NOP.
- ex_mem_addr  in  ADDR_W  effective byte address.
- ex_mem_sdata  in  32  store data (rt value).
- mem_wd  out  5  to MEM/WB.
- mem_wreg  out  1  to MEM/WB.
- mem_wdata  out  32  to MEM/WB.
- stallreq  out  1  hold upstream stages and the EX/MEM register.
- excp_adel  out  1  misaligned load, single-cycle pulse.
- excp_ades  out  1  misaligned store, single-cycle pulse.
- dbus_req  out  1  bus request, registered.
- dbus_we  out  1  1 = store, registered.
- dbus_addr  out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}, registered.
- dbus_sel  out  4  byte lanes, bit3 = bits 31:24, registered.
- dbus_wdata  out  32  store data, registered.
- dbus_ack  in  1  transaction complete; rdata valid in the same cycle.
- dbus_rdata  in  32  load data.

Behaviour:
- Reset: state IDLE.
  - dbus_req/we/addr/sel/wdata = 0; result register = 0.
  - While rst=1, combinational outputs are forced: mem_wd=0, mem_wreg=0, mem_wdata=0, stallreq=0, excp_*=0.
- Upstream contract: while stallreq=1, all ex_* inputs are held stable. MEM/WB has no stall, so bubble cycles present mem_wreg=0.
- Misalignment: LH/LHU/SH with addr[0]≠0, or LW/SW with addr[1:0]≠0.
- State IDLE:
  - NOP or invalid op: pass-through, mem_wd/wreg/wdata = ex_*; stallreq=0.
  - Misaligned op: no bus request; excp_adel (loads) or excp_ades (stores) = 1; mem_wreg=0; stallreq=0; stay IDLE.
  - Aligned memory op:
    - Outputs this cycle: stallreq=1, mem_wreg=0.
    - Registered at clock edge: dbus_req=1, dbus_we, dbus_addr, dbus_sel, dbus_wdata.
    - Next state: BUSY.
- Lane mapping (big-endian):
  - Byte: addr[1:0] 00→sel 1000, 01→0100, 10→0010, 11→0001.
  - Half: addr[1] 0→1100, 1→0011.
  - Word: 1111.
  - Store data replicated across lanes: SB {4{sdata[7:0]}}, SH {2{sdata[15:0]}}, SW sdata.
- State BUSY:
  - stallreq=1, mem_wreg=0; dbus_* held unchanged.
  - On dbus_ack=1:
    - Capture the extracted load value into the result register.
    - Extraction: selected lane; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
    - Clear dbus_req/dbus_we at the same edge; next state DONE.
  - With no ack, remain indefinitely (no timeout).
- State DONE:
  - stallreq=0; mem_wd=ex_wd; mem_wreg=ex_wreg.
  - mem_wdata = result register for loads, ex_wdata for stores.
  - Next state IDLE; upstream advances at this edge.
- Latency: minimum 3 cycles per memory op (IDLE issue, BUSY with immediate ack, DONE); each extra BUSY cycle adds 1.
- dbus_ack outside BUSY is ignored.
- Reset mid-transaction: any state → IDLE next edge with dbus_req=0; the transaction is abandoned.
- Back-to-back memory ops: the next op is sampled in IDLE the cycle after DONE, so there are no gaps other than those described.

Test Plan:
- Reset, then ex_mem_op=0, ex_wd=5, ex_wreg=1, ex_wdata=0x1234 → same cycle mem_wd=5, mem_wreg=1, mem_wdata=0x1234, stallreq=0, dbus_req stays 0.
- LB addr=0x1001, ack returned on first BUSY cycle with rdata=0x11F02233 → dbus_sel=0100, dbus_addr=0x1000, stallreq high 2 cycles; DONE mem_wdata=0xFFFFFFF0. Repeat as LBU → 0x000000F0.
- SH addr=0x2002, sdata=0xAAAA8765, ack delayed 3 cycles → dbus_we=1, dbus_sel=0011, dbus_wdata=0x87658765; req held 4 cycles; stallreq deasserts only in DONE.
- LW addr=0x3002 → excp_adel=1 for one cycle, mem_wreg=0, no dbus_req. SW addr=0x3001 → excp_ades=1.
- LW addr=0x4000 followed by LH addr=0x4006, rdata 0xDEADBEEF then 0x0000807F → results 0xDEADBEEF and 0xFFFF807F, sel 1111 then 0011, each op 3 cycles.
- rst asserted during BUSY → next cycle dbus_req=0, state IDLE; a later ack pulse causes no output change.
